// File: rtl/quant_zigzag_sequencer.sv
// quant_zigzag_sequencer
// Captures one quantized 8x8 block per in_valid/in_ready handshake and streams
// it to the entropy coder one coefficient per cycle in JPEG zigzag order.
// in_coeffs is flat: element [row][col] sits at bits ((row*8+col)*COEFF_WIDTH +: COEFF_WIDTH).
// Build option: define QSEQ_DOUBLE_BUF_EN for two ping-pong block banks
// (capture while streaming, no bubble between blocks). Default is a single bank.
module quant_zigzag_sequencer #(
    parameter int BLOCK_SIZE  = 8,   // only 8 is meaningful: the zigzag ROM is fixed
    parameter int COEFF_WIDTH = 9
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [BLOCK_SIZE*BLOCK_SIZE*COEFF_WIDTH-1:0]  in_coeffs,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic [COEFF_WIDTH-1:0]                        out_coeff,
    output logic [5:0]                                    out_index,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic                                          out_last,
    output logic [5:0]                                    blk_last_nz,
    output logic                                          blk_all_zero
);

    localparam int NCOEF = BLOCK_SIZE * BLOCK_SIZE;
    localparam int BLK_W = NCOEF * COEFF_WIDTH;
`ifdef QSEQ_DOUBLE_BUF_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif

    // Zigzag position -> raster position (row*8+col); entry k at bits [k*6 +: 6].
    localparam logic [383:0] ZZ_ROM = {
        6'd63, 6'd62, 6'd55, 6'd47, 6'd54, 6'd61, 6'd60, 6'd53,
        6'd46, 6'd39, 6'd31, 6'd38, 6'd45, 6'd52, 6'd59, 6'd58,
        6'd51, 6'd44, 6'd37, 6'd30, 6'd23, 6'd15, 6'd22, 6'd29,
        6'd36, 6'd43, 6'd50, 6'd57, 6'd56, 6'd49, 6'd42, 6'd35,
        6'd28, 6'd21, 6'd14, 6'd7,  6'd6,  6'd13, 6'd20, 6'd27,
        6'd34, 6'd41, 6'd48, 6'd40, 6'd33, 6'd26, 6'd19, 6'd12,
        6'd5,  6'd4,  6'd11, 6'd18, 6'd25, 6'd32, 6'd24, 6'd17,
        6'd10, 6'd3,  6'd2,  6'd9,  6'd16, 6'd8,  6'd1,  6'd0
    };

    function automatic logic [5:0] zz_at(input logic [5:0] k);
        return ZZ_ROM[int'(k)*6 +: 6];
    endfunction

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t             state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic [BLK_W-1:0]   bank_q [NBANK];
    logic [5:0]         last_nz_q [NBANK];
    logic               all_zero_q [NBANK];
    logic               wr_sel, rd_sel, pend;
    logic               capture, xfer, done;
    logic [5:0]         cap_last_nz;
    logic               cap_all_zero;

    assign capture = in_valid && in_ready;
    assign xfer    = out_valid && out_ready;
    assign done    = xfer && (idx_q == 6'd63);

`ifdef QSEQ_DOUBLE_BUF_EN
    logic wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, pend_q, pend_d;

    // Bank pointers and the "second block waiting" flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            pend_q   <= pend_d;
        end
    end

    // Writes and reads each walk the two banks in turn, which keeps blocks in FIFO order.
    always_comb begin
        wr_sel_d = capture ? ~wr_sel_q : wr_sel_q;
        rd_sel_d = done ? ~rd_sel_q : rd_sel_q;
        pend_d   = pend_q;
        if (state_q == S_STREAM) begin
            if (done)
                pend_d = 1'b0;
            else if (capture)
                pend_d = 1'b1;
        end
    end

    assign wr_sel = wr_sel_q;
    assign rd_sel = rd_sel_q;
    assign pend   = pend_q;
`else
    assign wr_sel = 1'b0;
    assign rd_sel = 1'b0;
    assign pend   = 1'b0;
`endif

    // Last nonzero coefficient in zigzag order; the highest zigzag index wins.
    always_comb begin
        cap_last_nz  = 6'd0;
        cap_all_zero = 1'b1;
        for (int i = 0; i < NCOEF; i++) begin
            if (in_coeffs[int'(zz_at(6'(i)))*COEFF_WIDTH +: COEFF_WIDTH] != '0) begin
                cap_last_nz  = 6'(i);
                cap_all_zero = 1'b0;
            end
        end
    end

    // Block storage: written on capture only, never reset.
    always_ff @(posedge clk) begin
        if (capture)
            bank_q[wr_sel] <= in_coeffs;
    end

    // Per-bank metadata, registered alongside the block it describes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < NBANK; b++) begin
                last_nz_q[b]  <= 6'd0;
                all_zero_q[b] <= 1'b0;
            end
        end else if (capture) begin
            last_nz_q[wr_sel]  <= cap_last_nz;
            all_zero_q[wr_sel] <= cap_all_zero;
        end
    end

    // State and stream index registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: a finished block hands over directly to a waiting or just-captured one.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    state_d = S_STREAM;
                    idx_d   = 6'd0;
                end
            end
            S_STREAM: begin
                if (done) begin
                    state_d = (pend || capture) ? S_STREAM : S_IDLE;
                    idx_d   = 6'd0;
                end else if (xfer) begin
                    idx_d = idx_q + 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: everything derives from registers, so it holds while out_ready is low.
    always_comb begin
        out_valid    = (state_q == S_STREAM);
`ifdef QSEQ_DOUBLE_BUF_EN
        in_ready     = !pend;
`else
        in_ready     = (state_q == S_IDLE);
`endif
        out_index    = idx_q;
        out_last     = (state_q == S_STREAM) && (idx_q == 6'd63);
        out_coeff    = bank_q[rd_sel][int'(zz_at(idx_q))*COEFF_WIDTH +: COEFF_WIDTH];
        blk_last_nz  = last_nz_q[rd_sel];
        blk_all_zero = all_zero_q[rd_sel];
    end

endmodule

// File: tb/tb_quant_zigzag_sequencer.sv
// Directed bench for quant_zigzag_sequencer (either buffering option).
module tb_quant_zigzag_sequencer;

    localparam int W = 9;
`ifdef QSEQ_DOUBLE_BUF_EN
    localparam int DB = 1;
`else
    localparam int DB = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [64*W-1:0] in_coeffs;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    out_coeff;
    logic [5:0]      out_index;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic [5:0]      blk_last_nz;
    logic            blk_all_zero;

    int total = 0;
    int bad   = 0;
    int blk_ref [64];
    int zz_r [64];
    int zz_c [64];
    int seq [64];

    always #5 clk = ~clk;

    quant_zigzag_sequencer #(.BLOCK_SIZE(8), .COEFF_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_coeffs(in_coeffs), .in_valid(in_valid),
        .in_ready(in_ready), .out_coeff(out_coeff), .out_index(out_index),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .blk_last_nz(blk_last_nz), .blk_all_zero(blk_all_zero)
    );

    task automatic check_val(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // Zigzag walk by anti-diagonals: even diagonals go up-right, odd go down-left.
    task automatic build_zz();
        int n = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz_r[n] = r; zz_c[n] = s - r; n++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
                    zz_r[n] = r; zz_c[n] = s - r; n++;
                end
            end
        end
    endtask

    task automatic pack_ref();
        for (int i = 0; i < 64; i++)
            in_coeffs[i*W +: W] = W'(blk_ref[i]);
    endtask

    task automatic fill_ref(input int v);
        for (int i = 0; i < 64; i++) blk_ref[i] = v;
    endtask

    // Called at a negedge; returns at the negedge right after the capture edge.
    task automatic load_block();
        int g = 0;
        pack_ref();
        in_valid = 1'b1;
        while (!in_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) check_val("load_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Consumes one block starting at the negedge after capture.
    task automatic run_stream(input string nm, input int tog, input int exp_nz, input int exp_az);
        int k = 0;
        int vcyc = 0;
        int g = 0;
        while (k < 64 && g < 400) begin
            g++;
            if (!out_valid) begin
                check_val({nm, "_valid"}, 0, 1);
                break;
            end
            vcyc++;
            check_val({nm, "_index"}, int'(out_index), k);
            check_val({nm, "_coeff"}, int'($signed(out_coeff)), blk_ref[zz_r[k]*8 + zz_c[k]]);
            check_val({nm, "_last"}, int'(out_last), (k == 63) ? 1 : 0);
            check_val({nm, "_lastnz"}, int'(blk_last_nz), exp_nz);
            check_val({nm, "_allzero"}, int'(blk_all_zero), exp_az);
            if (k == 5) check_val({nm, "_inready"}, int'(in_ready), DB);
            seq[k] = int'($signed(out_coeff));
            out_ready = tog ? ~out_ready : 1'b1;
            if (out_ready) k++;
            @(negedge clk);
        end
        check_val({nm, "_vcycles"}, vcyc, tog ? 128 : 64);
        check_val({nm, "_valid_after"}, int'(out_valid), 0);
        check_val({nm, "_last_after"}, int'(out_last), 0);
        out_ready = 1'b1;
    endtask

    task automatic back_to_back();
        int nv = 0;
        int gap = 0;
        int caps = 0;
        int g = 0;
        bit swap = 0;
        bit drop = 0;
        fill_ref(1);
        pack_ref();
        in_valid = 1'b1;
        while (nv < 128 && g < 400) begin
            g++;
            if (swap) begin
                fill_ref(-1);
                pack_ref();
                swap = 0;
            end
            if (drop) begin
                in_valid = 1'b0;
                drop = 0;
            end
            if (out_valid) begin
                check_val("b2b_index", int'(out_index), nv % 64);
                check_val("b2b_coeff", int'($signed(out_coeff)), (nv < 64) ? 1 : -1);
                nv++;
            end else if (nv == 64) begin
                gap++;
            end
            if (in_valid && in_ready) begin
                caps++;
                if (caps == 1) swap = 1;
                else drop = 1;
            end
            @(negedge clk);
        end
        check_val("b2b_count", nv, 128);
        check_val("b2b_gap", gap, DB ? 0 : 1);
        check_val("b2b_captures", caps, 2);
        check_val("b2b_valid_after", int'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        build_zz();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_coeffs = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_in_ready", int'(in_ready), 1);
        check_val("rst_out_index", int'(out_index), 0);
        check_val("rst_out_last", int'(out_last), 0);
        check_val("rst_last_nz", int'(blk_last_nz), 0);
        check_val("rst_all_zero", int'(blk_all_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp block r*8+c: zigzag sequence 0,1,8,16,9,2,3,10,...,63
        for (int i = 0; i < 64; i++) blk_ref[i] = i;
        load_block();
        run_stream("ramp", 0, 63, 0);
        check_val("ramp_seq2", seq[2], 8);
        check_val("ramp_seq3", seq[3], 16);
        check_val("ramp_seq7", seq[7], 10);
        check_val("ramp_seq63", seq[63], 63);

        // Single -5 at row 3, col 4: zigzag position 31
        fill_ref(0);
        blk_ref[3*8 + 4] = -5;
        load_block();
        run_stream("single", 0, 31, 0);
        check_val("single_seq31", seq[31], -5);
        check_val("single_seq30", seq[30], 0);

        // All-zero block
        fill_ref(0);
        load_block();
        run_stream("zero", 0, 0, 1);

        // Ramp with out_ready toggling every cycle: 128 valid cycles
        for (int i = 0; i < 64; i++) blk_ref[i] = i;
        load_block();
        run_stream("toggle", 1, 63, 0);

        // A = all 1, B = all -1 with in_valid held
        back_to_back();

        // Reset in the middle of a stream
        for (int i = 0; i < 64; i++) blk_ref[i] = i;
        load_block();
        g = 0;
        while (out_index != 6'd20 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check_val("midrst_reach20", int'(out_index), 20);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_out_valid", int'(out_valid), 0);
        check_val("midrst_in_ready", int'(in_ready), 1);
        check_val("midrst_out_index", int'(out_index), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh block after reset streams from index 0
        for (int i = 0; i < 64; i++) blk_ref[i] = 63 - i;
        load_block();
        run_stream("post_rst", 0, 62, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
